// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: group-aligned PC, slot mask, redirect arbitration.
// Optional FETCH_PC_ADDR_CHECK_EN flags misaligned PCs and blanks the mask.
module fetch_pc_unit #(
   parameter int FETCH_WIDTH = 2,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_VEC = 32'hBFC0_0000,
   localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ready,
   input  logic                   hold_pc,
   input  logic                   except_valid,
   input  logic [ADDR_WIDTH-1:0]  except_vec,
   input  logic                   resolve_valid,
   input  logic [ADDR_WIDTH-1:0]  resolve_target,
   input  logic                   replay_valid,
   input  logic [ADDR_WIDTH-1:0]  replay_vaddr,
   input  logic                   presolve_valid,
   input  logic [ADDR_WIDTH-1:0]  presolve_target,
   input  logic                   predict_valid,
   input  logic [SW-1:0]          predict_slot,
   input  logic [ADDR_WIDTH-1:0]  predict_target,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic                   pc_en,
   output logic [FETCH_WIDTH-1:0] slot_mask,
   output logic                   redirect_pending,
   output logic                   pc_addr_err
);

   typedef enum logic {SEQ, DS_WAIT} state_e;

   localparam logic [ADDR_WIDTH-1:0] GB = ADDR_WIDTH'(FETCH_WIDTH * 4);
   localparam logic [ADDR_WIDTH-1:0] GMASK = ~(GB - ADDR_WIDTH'(1));
   localparam logic [ADDR_WIDTH-1:0] OMASK = ADDR_WIDTH'(FETCH_WIDTH - 1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   ds_q, ds_d;
   logic                    pend_v_q, pend_v_d;
   logic [1:0]              pend_prio_q, pend_prio_d;
   logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;

   logic                    red_v;
   logic [1:0]              red_prio;
   logic [ADDR_WIDTH-1:0]   red_tgt;
   logic [ADDR_WIDTH-1:0]   base;
   logic [SW-1:0]           off;
   logic [FETCH_WIDTH-1:0]  mask_raw;

   assign base = pc_q & GMASK;
   assign off = SW'((pc_q >> 2) & OMASK);

   // Priority encode: except(3) > resolve(2) > replay(1) > presolve(0)
   always_comb begin
      red_v = 1'b1;
      red_prio = 2'd0;
      red_tgt = presolve_target;
      if (except_valid) begin
         red_prio = 2'd3;
         red_tgt = except_vec;
      end else if (resolve_valid) begin
         red_prio = 2'd2;
         red_tgt = resolve_target;
      end else if (replay_valid) begin
         red_prio = 2'd1;
         red_tgt = replay_vaddr;
      end else if (!presolve_valid) begin
         red_v = 1'b0;
      end
   end

   always_comb begin
      pc_d = pc_q;
      state_d = state_q;
      ds_d = ds_q;
      pend_v_d = pend_v_q;
      pend_prio_d = pend_prio_q;
      pend_tgt_d = pend_tgt_q;
      if (ready) begin
         pc_d = base + GB;
         if (state_q == DS_WAIT) begin
            pc_d = ds_q;
            state_d = SEQ;
         end else if (predict_valid) begin
            if (int'(predict_slot) == FETCH_WIDTH - 1) begin
               state_d = DS_WAIT;
               ds_d = predict_target;
            end else if (int'(predict_slot) < FETCH_WIDTH - 1) begin
               pc_d = predict_target;
            end
         end
         if (hold_pc) begin
            pc_d = pc_q;
            state_d = state_q;
            ds_d = ds_q;
         end
         if (pend_v_q) begin
            pc_d = pend_tgt_q;
            state_d = SEQ;
         end
         pend_v_d = 1'b0;
         if (red_v) begin
            pc_d = red_tgt;
            state_d = SEQ;
         end
      end else if (red_v && (!pend_v_q || red_prio >= pend_prio_q)) begin
         pend_v_d = 1'b1;
         pend_prio_d = red_prio;
         pend_tgt_d = red_tgt;
      end
   end

   // Delay slot of the predicted branch stays valid
   always_comb begin
      mask_raw = '0;
      if (state_q == DS_WAIT) begin
         mask_raw[0] = 1'b1;
      end else begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask_raw[i] = (i >= int'(off));
            if (predict_valid && (i > int'(predict_slot) + 1))
               mask_raw[i] = 1'b0;
         end
      end
   end

`ifdef FETCH_PC_ADDR_CHECK_EN
   assign pc_addr_err = |pc_q[1:0];
   assign slot_mask = pc_addr_err ? '0 : mask_raw;
`else
   assign pc_addr_err = 1'b0;
   assign slot_mask = mask_raw;
`endif

   assign pc = pc_q;
   assign pc_en = ready;
   assign redirect_pending = pend_v_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= BOOT_VEC;
         state_q <= SEQ;
         ds_q <= '0;
         pend_v_q <= 1'b0;
         pend_prio_q <= 2'd0;
         pend_tgt_q <= '0;
      end else begin
         pc_q <= pc_d;
         state_q <= state_d;
         ds_q <= ds_d;
         pend_v_q <= pend_v_d;
         pend_prio_q <= pend_prio_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit at FETCH_WIDTH=2.
// Address-check expectations follow FETCH_PC_ADDR_CHECK_EN.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst;
   logic        ready;
   logic        hold_pc;
   logic        except_valid;
   logic [31:0] except_vec;
   logic        resolve_valid;
   logic [31:0] resolve_target;
   logic        replay_valid;
   logic [31:0] replay_vaddr;
   logic        presolve_valid;
   logic [31:0] presolve_target;
   logic        predict_valid;
   logic [0:0]  predict_slot;
   logic [31:0] predict_target;
   logic [31:0] pc;
   logic        pc_en;
   logic [1:0]  slot_mask;
   logic        redirect_pending;
   logic        pc_addr_err;

   int vectors = 0;
   int miscompares = 0;

   fetch_pc_unit #(
      .FETCH_WIDTH(2),
      .ADDR_WIDTH(32),
      .BOOT_VEC(32'hBFC0_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ready(ready),
      .hold_pc(hold_pc),
      .except_valid(except_valid),
      .except_vec(except_vec),
      .resolve_valid(resolve_valid),
      .resolve_target(resolve_target),
      .replay_valid(replay_valid),
      .replay_vaddr(replay_vaddr),
      .presolve_valid(presolve_valid),
      .presolve_target(presolve_target),
      .predict_valid(predict_valid),
      .predict_slot(predict_slot),
      .predict_target(predict_target),
      .pc(pc),
      .pc_en(pc_en),
      .slot_mask(slot_mask),
      .redirect_pending(redirect_pending),
      .pc_addr_err(pc_addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hold_pc = 1'b0;
      except_valid = 1'b0;
      resolve_valid = 1'b0;
      replay_valid = 1'b0;
      presolve_valid = 1'b0;
      predict_valid = 1'b0;
      predict_slot = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ready = 1'b1;
      except_vec = '0;
      resolve_target = '0;
      replay_vaddr = '0;
      presolve_target = '0;
      predict_target = '0;
      clr();
      #1;
      chk("rst_pc", pc, 32'hBFC0_0000);
      chk("rst_mask", 32'(slot_mask), 32'h3);
      chk("rst_pend", 32'(redirect_pending), 32'h0);
      chk("rst_err", 32'(pc_addr_err), 32'h0);
      chk("rst_pc_en", 32'(pc_en), 32'h1);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("boot_pc", pc, 32'hBFC0_0000);
      tick();
      chk("seq1", pc, 32'hBFC0_0008);
      tick();
      chk("seq2", pc, 32'hBFC0_0010);
      chk("seq2_mask", 32'(slot_mask), 32'h3);

      presolve_valid = 1'b1;
      presolve_target = 32'h8000_0004;
      tick();
      clr();
      #1;
      chk("off1_pc", pc, 32'h8000_0004);
      chk("off1_mask", 32'(slot_mask), 32'h2);
      tick();
      chk("off1_next", pc, 32'h8000_0008);
      chk("off1_next_mask", 32'(slot_mask), 32'h3);

      replay_valid = 1'b1;
      replay_vaddr = 32'h8000_0000;
      tick();
      clr();
      predict_valid = 1'b1;
      predict_slot = 1'b1;
      predict_target = 32'h8000_1000;
      #1;
      chk("spill_mask", 32'(slot_mask), 32'h3);
      tick();
      predict_slot = 1'b0;
      predict_target = 32'h1234_0000;
      #1;
      chk("ds_pc", pc, 32'h8000_0008);
      chk("ds_mask", 32'(slot_mask), 32'h1);
      tick();
      clr();
      #1;
      chk("ds_tgt", pc, 32'h8000_1000);
      chk("ds_tgt_mask", 32'(slot_mask), 32'h3);

      predict_valid = 1'b1;
      predict_slot = 1'b0;
      predict_target = 32'h8000_4000;
      tick();
      clr();
      #1;
      chk("pred0", pc, 32'h8000_4000);

      ready = 1'b0;
      replay_valid = 1'b1;
      replay_vaddr = 32'h8000_2000;
      #1;
      chk("stall_pc_en", 32'(pc_en), 32'h0);
      tick();
      clr();
      except_valid = 1'b1;
      except_vec = 32'hBFC0_0380;
      #1;
      chk("stall1_pc", pc, 32'h8000_4000);
      chk("stall1_pend", 32'(redirect_pending), 32'h1);
      tick();
      clr();
      chk("stall2_pc", pc, 32'h8000_4000);
      tick();
      chk("stall3_pc", pc, 32'h8000_4000);
      chk("stall3_pend", 32'(redirect_pending), 32'h1);
      ready = 1'b1;
      tick();
      chk("pend_apply", pc, 32'hBFC0_0380);
      chk("pend_clear", 32'(redirect_pending), 32'h0);
      tick();
      chk("pend_after", pc, 32'hBFC0_0388);

      ready = 1'b0;
      resolve_valid = 1'b1;
      resolve_target = 32'h8000_5000;
      tick();
      clr();
      presolve_valid = 1'b1;
      presolve_target = 32'h8000_6000;
      tick();
      clr();
      ready = 1'b1;
      tick();
      chk("pend_keep_hi", pc, 32'h8000_5000);

      hold_pc = 1'b1;
      tick();
      clr();
      chk("hold", pc, 32'h8000_5000);

      predict_valid = 1'b1;
      predict_slot = 1'b1;
      predict_target = 32'h8000_7000;
      tick();
      clr();
      #1;
      chk("ds2_pc", pc, 32'h8000_5008);
      chk("ds2_mask", 32'(slot_mask), 32'h1);
      resolve_valid = 1'b1;
      resolve_target = 32'h8000_3000;
      tick();
      clr();
      #1;
      chk("ds_resolve", pc, 32'h8000_3000);
      chk("ds_resolve_mask", 32'(slot_mask), 32'h3);
      tick();
      chk("ds_discard", pc, 32'h8000_3008);

      ready = 1'b0;
      replay_valid = 1'b1;
      replay_vaddr = 32'h8000_8000;
      tick();
      clr();
      ready = 1'b1;
      presolve_valid = 1'b1;
      presolve_target = 32'h8000_9000;
      tick();
      clr();
      #1;
      chk("live_wins", pc, 32'h8000_9000);
      chk("live_pend", 32'(redirect_pending), 32'h0);
      tick();
      chk("live_after", pc, 32'h8000_9008);

      presolve_valid = 1'b1;
      presolve_target = 32'hFFFF_FFF8;
      tick();
      clr();
      tick();
      chk("wrap", pc, 32'h0000_0000);

      predict_valid = 1'b1;
      predict_slot = 1'b1;
      predict_target = 32'h8000_A000;
      tick();
      clr();
      #1;
      chk("ds3_pc", pc, 32'h0000_0008);
      ready = 1'b0;
      replay_valid = 1'b1;
      replay_vaddr = 32'h8000_B000;
      tick();
      clr();
      #1;
      chk("pre_rst_pend", 32'(redirect_pending), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_pc", pc, 32'hBFC0_0000);
      chk("mid_rst_pend", 32'(redirect_pending), 32'h0);
      chk("mid_rst_mask", 32'(slot_mask), 32'h3);
      rst = 1'b0;
      ready = 1'b1;
      tick();
      chk("post_rst1", pc, 32'hBFC0_0008);
      tick();
      chk("post_rst2", pc, 32'hBFC0_0010);

      presolve_valid = 1'b1;
      presolve_target = 32'h8000_0002;
      tick();
      clr();
      #1;
      chk("mis_pc", pc, 32'h8000_0002);
`ifdef FETCH_PC_ADDR_CHECK_EN
      chk("mis_err", 32'(pc_addr_err), 32'h1);
      chk("mis_mask", 32'(slot_mask), 32'h0);
`else
      chk("mis_err", 32'(pc_addr_err), 32'h0);
      chk("mis_mask", 32'(slot_mask), 32'h3);
`endif
      except_valid = 1'b1;
      except_vec = 32'hBFC0_0380;
      tick();
      clr();
      #1;
      chk("mis_clr_pc", pc, 32'hBFC0_0380);
      chk("mis_clr_err", 32'(pc_addr_err), 32'h0);
      chk("mis_clr_mask", 32'(slot_mask), 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised next-generation fetch PC unit for the front end.
- Produces the aligned fetch-group PC and a per-slot valid mask for a FETCH_WIDTH-wide instruction fetch.
- Arbitrates exception, resolved-branch, replay and presolved redirects.
- Tracks delay slots that spill into the next fetch group, and holds PC across stalls without losing redirects.

Parameters:
- FETCH_WIDTH, 2, instructions per fetch group; power of two, 1..8.
- ADDR_WIDTH, 32, virtual address width.
- BOOT_VEC, 32'hBFC0_0000, reset PC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ready  in  1  fetch stage accepts a new PC this cycle
- hold_pc  in  1  re-fetch the current group
- except_valid  in  1  exception redirect
- except_vec  in  ADDR_WIDTH  exception target
- resolve_valid  in  1  resolved-branch mispredict redirect
- resolve_target  in  ADDR_WIDTH  corrected target
- replay_valid  in  1  replay redirect
- replay_vaddr  in  ADDR_WIDTH  replay target
- presolve_valid  in  1  presolved mispredict redirect
- presolve_target  in  ADDR_WIDTH  presolved target
- predict_valid  in  1  taken branch predicted in the current group
- predict_slot  in  log2(FETCH_WIDTH) (min 1)  slot index of the predicted branch
- predict_target  in  ADDR_WIDTH  predicted target
- pc  out  ADDR_WIDTH  current fetch PC
- pc_en  out  1  fetch valid (= ready)
- slot_mask  out  FETCH_WIDTH  valid slots of the current group
- redirect_pending  out  1  latched redirect awaiting ready
- pc_addr_err  out  1  see Optional Feature

Behaviour:
- Definitions:
  - GB = FETCH_WIDTH*4.
  - off = pc[log2(GB)-1:2].
  - base = pc with the low log2(GB) bits cleared.
- Reset (async):
  - pc = BOOT_VEC, state = SEQ, redirect_pending = 0, pc_addr_err = 0.
  - slot_mask derives from BOOT_VEC.
- Redirect priority: except > resolve > replay > presolve. The winner is the redirect target.
- When ready = 1, pc updates each clk to npc, evaluated in this order (later items override earlier):
  1. Default npc = base + GB.
  2. Prediction: predict_valid with predict_slot < FETCH_WIDTH-1 sets npc = predict_target.
  3. Spill: predict_valid with predict_slot == FETCH_WIDTH-1 keeps npc = base + GB, sets state DS_WAIT and latches predict_target into ds_target.
  4. In DS_WAIT: npc = ds_target and state returns to SEQ. Predict inputs are ignored in this state.
  5. hold_pc: npc = pc; state and ds_target are unchanged.
  6. Pending redirect latched earlier: npc = pending target; pending clears.
  7. Live redirect: npc = winner target, state forced to SEQ. A live redirect beats a pending one.
- When ready = 0:
  - pc, state and ds_target hold.
  - Any redirect input is latched into the pending register. An incoming redirect overwrites the pending one only if its priority is >= the stored priority.
  - redirect_pending = 1 from the cycle after the latch.
- slot_mask:
  - Bits [off .. FETCH_WIDTH-1] are set.
  - If predict_valid in SEQ: bits above predict_slot+1 are cleared (delay slot kept).
  - In DS_WAIT: only bit 0 is set.
  - Mask is combinational from pc, state and predict inputs.
- Arithmetic: base + GB wraps modulo 2^ADDR_WIDTH with no flag.
- Reset mid-DS_WAIT or with a pending redirect: both are discarded.

Optional Feature:
- Macro: FETCH_PC_ADDR_CHECK_EN.
- When defined:
  - pc_addr_err = (pc[1:0] != 0), combinational.
  - slot_mask is forced to 0 while the flag is set.
  - The next redirect clears the condition.
- When undefined: pc_addr_err is tied to 0 and no check logic is generated.

Test Plan:
- FETCH_WIDTH=2, reset release, ready=1, no events -> pc sequence BFC00000, BFC00008, BFC00010; slot_mask = 2'b11.
- pc=80000004 (off=1) -> slot_mask = 2'b10; next pc = 80000008.
- pc=80000000 with predict_valid, slot=1, target 80001000 -> next pc 80000008 with mask 2'b01, then 80001000.
- ready=0 for 3 cycles with replay_valid (80002000) in cycle 1 and except_valid (BFC00380) in cycle 2 -> pc holds and redirect_pending=1; on ready=1, pc = BFC00380, then pending clears.
- During DS_WAIT, resolve_valid with target 80003000 -> pc = 80003000, state SEQ, ds_target discarded.
- With FETCH_PC_ADDR_CHECK_EN defined, presolve_target 80000002 -> pc_addr_err = 1 and slot_mask = 0; a subsequent except_valid clears both.
